// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg
// ----------------------------------------------------------------------------
// Purpose:
//   Shared timing constants for the 640x480 @ 60 Hz display pipeline.
//   The timing generator uses these as its parameter defaults. Downstream
//   display stages import the same package so every stage agrees on the
//   raster geometry and sync polarities.
//
// Contents:
//   CORDW_480P           signed coordinate width used by the display stages
//   H_RES_480P           active pixels per line
//   V_RES_480P           active lines per frame
//   H_FP/H_SYNC/H_BP     horizontal front porch, sync width and back porch (pixels)
//   V_FP/V_SYNC/V_BP     vertical front porch, sync height and back porch (lines)
//   H_POL/V_POL          sync active level (0 = active-low)
//   H_TOTAL/V_TOTAL      derived full line length and full frame height
// ============================================================================
package display_pkg;

    localparam int CORDW_480P   = 16;

    localparam int H_RES_480P   = 640;
    localparam int V_RES_480P   = 480;

    localparam int H_FP_480P    = 16;
    localparam int H_SYNC_480P  = 96;
    localparam int H_BP_480P    = 48;

    localparam int V_FP_480P    = 10;
    localparam int V_SYNC_480P  = 2;
    localparam int V_BP_480P    = 33;

    localparam logic H_POL_480P = 1'b0;
    localparam logic V_POL_480P = 1'b0;

    // Full raster dimensions, blanking included (800 x 525 with defaults).
    localparam int H_TOTAL_480P = H_RES_480P + H_FP_480P + H_SYNC_480P + H_BP_480P;
    localparam int V_TOTAL_480P = V_RES_480P + V_FP_480P + V_SYNC_480P + V_BP_480P;

endpackage : display_pkg

// File: rtl/display_480p.sv
// ============================================================================
// display_480p
// ----------------------------------------------------------------------------
// Purpose:
//   Raster timing generator for a 640x480 display. It walks a signed
//   (sx, sy) position across the full raster. Blanking sits at negative
//   coordinates, so the visible area starts at (0, 0). Sync, data-enable and
//   strobe outputs are generated for that position.
//
//   Every output is a register, and all of them are computed from the same
//   next position. The outputs seen in any cycle therefore describe exactly
//   one (sx, sy) with no skew between them.
//
// Parameters:
//   CORDW                signed coordinate width. It must be able to hold
//                        both V_STA and H_RES-1.
//   H_RES, V_RES         active pixels per line / active lines per frame
//   H_FP, H_SYNC, H_BP   horizontal porch and sync widths (pixels)
//   V_FP, V_SYNC, V_BP   vertical porch and sync heights (lines)
//   H_POL, V_POL         sync active level (0 = active-low)
//
// Ports:
//   clk_pix   in   pixel clock (only clock)
//   rst_pix   in   synchronous active-high reset
//   hsync     out  horizontal sync, at H_POL while asserted
//   vsync     out  vertical sync, at V_POL while asserted
//   de        out  data enable, high only for active pixels
//   frame     out  one-cycle strobe at the first position of each frame
//   line      out  one-cycle strobe at the first position of each line
//   sx        out  signed horizontal position
//   sy        out  signed vertical position
// ============================================================================
module display_480p
    import display_pkg::*;
#(
    parameter int   CORDW  = CORDW_480P,
    parameter int   H_RES  = H_RES_480P,
    parameter int   V_RES  = V_RES_480P,
    parameter int   H_FP   = H_FP_480P,
    parameter int   H_SYNC = H_SYNC_480P,
    parameter int   H_BP   = H_BP_480P,
    parameter int   V_FP   = V_FP_480P,
    parameter int   V_SYNC = V_SYNC_480P,
    parameter int   V_BP   = V_BP_480P,
    parameter logic H_POL  = H_POL_480P,
    parameter logic V_POL  = V_POL_480P
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy
);

    // Raster landmarks as signed CORDW-bit constants. Every comparison below
    // is then signed on both sides. The blanking region starts at a negative
    // coordinate, so any unsigned comparison would put it after the active
    // area.
    localparam logic signed [CORDW-1:0] H_STA  = CORDW'(-(H_FP + H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_STA = CORDW'(-(H_SYNC + H_BP));
    localparam logic signed [CORDW-1:0] HS_END = CORDW'(-H_BP - 1);
    localparam logic signed [CORDW-1:0] H_LAST = CORDW'(H_RES - 1);

    localparam logic signed [CORDW-1:0] V_STA  = CORDW'(-(V_FP + V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_STA = CORDW'(-(V_SYNC + V_BP));
    localparam logic signed [CORDW-1:0] VS_END = CORDW'(-V_BP - 1);
    localparam logic signed [CORDW-1:0] V_LAST = CORDW'(V_RES - 1);

    localparam logic signed [CORDW-1:0] ZERO   = '0;
    localparam logic signed [CORDW-1:0] ONE    = CORDW'(1);

    logic signed [CORDW-1:0] r_sx;
    logic signed [CORDW-1:0] r_sy;
    logic                    r_hsync;
    logic                    r_vsync;
    logic                    r_de;
    logic                    r_frame;
    logic                    r_line;

    logic signed [CORDW-1:0] w_sxNext;
    logic signed [CORDW-1:0] w_syNext;
    logic                    w_hsyncNext;
    logic                    w_vsyncNext;
    logic                    w_deNext;
    logic                    w_frameNext;
    logic                    w_lineNext;

    // Next raster position. The vertical counter only moves on the cycle
    // where the horizontal counter wraps. The last line therefore wraps to
    // V_STA on the same edge that the last pixel wraps to H_STA.
    always_comb begin
        w_sxNext = r_sx + ONE;
        w_syNext = r_sy;
        if (r_sx == H_LAST) begin
            w_sxNext = H_STA;
            if (r_sy == V_LAST) begin
                w_syNext = V_STA;
            end else begin
                w_syNext = r_sy + ONE;
            end
        end
    end

    // All outputs decode the next position rather than the current one.
    // Registering them then lines the decoded flags up with the registered
    // coordinates in the same cycle.
    always_comb begin
        w_hsyncNext = ~H_POL;
        w_vsyncNext = ~V_POL;
        if ((w_sxNext >= HS_STA) && (w_sxNext <= HS_END)) begin
            w_hsyncNext = H_POL;
        end
        if ((w_syNext >= VS_STA) && (w_syNext <= VS_END)) begin
            w_vsyncNext = V_POL;
        end
        w_deNext    = (w_sxNext >= ZERO) && (w_syNext >= ZERO);
        w_lineNext  = (w_sxNext == H_STA);
        w_frameNext = (w_sxNext == H_STA) && (w_syNext == V_STA);
    end

    // Reset parks the raster at its first position. The strobes are held low
    // there, so the reset position produces no frame or line pulse. The first
    // edge after release then advances to H_STA+1.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_sx    <= H_STA;
            r_sy    <= V_STA;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
            r_frame <= 1'b0;
            r_line  <= 1'b0;
        end else begin
            r_sx    <= w_sxNext;
            r_sy    <= w_syNext;
            r_hsync <= w_hsyncNext;
            r_vsync <= w_vsyncNext;
            r_de    <= w_deNext;
            r_frame <= w_frameNext;
            r_line  <= w_lineNext;
        end
    end

    assign sx    = r_sx;
    assign sy    = r_sy;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;
    assign frame = r_frame;
    assign line  = r_line;

endmodule : display_480p

// File: doc/display_480p.md
DISPLAY_480P -- requirements
Module: display_480p

Interface
REQ-001 SHALL have parameter CORDW, default 16, the signed coordinate width in bits.
REQ-002 SHALL have parameter H_RES, default 640, active pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, active lines per frame.
REQ-004 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, the horizontal front porch, sync and back porch widths in pixels.
REQ-005 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, the vertical front porch, sync and back porch heights in lines.
REQ-006 SHALL have parameters H_POL and V_POL, default 0, the sync active level (0 = active-low).
REQ-007 SHALL have port clk_pix, input, 1 bit, the pixel clock; this is the only clock.
REQ-008 SHALL have port rst_pix, input, 1 bit, reset; synchronous, active-high.
REQ-009 SHALL have port hsync, output, 1 bit, horizontal sync at level H_POL when asserted.
REQ-010 SHALL have port vsync, output, 1 bit, vertical sync at level V_POL when asserted.
REQ-011 SHALL have port de, output, 1 bit, data enable, high only for active pixels.
REQ-012 SHALL have port frame, output, 1 bit, one-cycle strobe at the first position of each frame.
REQ-013 SHALL have port line, output, 1 bit, one-cycle strobe at the first position of each line.
REQ-014 SHALL have port sx, output, signed CORDW bits, horizontal position.
REQ-015 SHALL have port sy, output, signed CORDW bits, vertical position.

Function
REQ-016 SHALL define H_STA = -(H_FP+H_SYNC+H_BP) and V_STA = -(V_FP+V_SYNC+V_BP); with defaults these are -160 and -45.
REQ-017 SHALL count sx from H_STA to H_RES-1 and then wrap to H_STA, giving 800 positions per line with defaults.
REQ-018 SHALL advance sy by one when sx wraps, and wrap sy from V_RES-1 to V_STA, giving 525 lines per frame with defaults.
REQ-019 SHALL assert hsync for sx in [H_STA+H_FP, H_STA+H_FP+H_SYNC-1] = [-144, -49] and hold it at !H_POL elsewhere.
REQ-020 SHALL assert vsync for sy in [V_STA+V_FP, V_STA+V_FP+V_SYNC-1] = [-35, -34] and hold it at !V_POL elsewhere.
REQ-021 SHALL drive de = 1 exactly when sx >= 0 and sy >= 0.
REQ-022 SHALL drive line = 1 exactly when sx == H_STA, and frame = 1 exactly when sx == H_STA and sy == V_STA.
REQ-023 SHALL register every output, and all outputs in any given cycle SHALL describe the same (sx, sy) position; there is zero skew between outputs.
REQ-024 SHALL use signed comparisons throughout and SHALL require CORDW to hold both V_STA and H_RES-1 without overflow.
REQ-025 SHALL begin each vertical wrap (sy: V_RES-1 -> V_STA) on the same cycle as the horizontal wrap (sx: H_RES-1 -> H_STA).

Reset
REQ-026 SHALL, while rst_pix is high, set sx = H_STA, sy = V_STA, hsync = !H_POL, vsync = !V_POL, and de = frame = line = 0.
REQ-027 SHALL present sx = H_STA+1, sy = V_STA on the first cycle after rst_pix falls, with no frame or line strobe for the reset position.
REQ-028 SHALL restore the REQ-026 values on the next clock edge when rst_pix is asserted mid-frame, regardless of the current position.

Structure
REQ-029 SHALL take the default 640x480 timing constants (resolutions, porch and sync widths, polarities) from a shared package, display_pkg, so that other display stages reuse them.
REQ-030 SHALL be a single module with no sub-module; the horizontal and vertical counters are implemented inline.

Verification
REQ-031 Release reset and run 420,000 cycles -> exactly one frame pulse, at cycle 419,999 after release (sx = -160, sy = -45), and 525 line pulses.
REQ-032 Within one line -> hsync low for exactly 96 consecutive cycles, sx = -144 to -49; de high for exactly 640 cycles, sx = 0 to 639.
REQ-033 Over one frame -> vsync low for exactly 2 lines (sy = -35, -34) and de asserted for 307,200 cycles in total.
REQ-034 At sx = 639, sy = 479 -> next cycle sx = -160, sy = -45, frame = 1, line = 1, de = 0.
REQ-035 Assert rst_pix at sx = 300, sy = 200 for 3 cycles -> outputs hold the REQ-026 values; first cycle after release gives sx = -159.
REQ-036 Set H_POL = V_POL = 1 -> sync pulses are active-high with identical positions and widths to REQ-032 and REQ-033.
